// File: rtl/input_debounce.sv
// input_debounce: two-flop synchroniser plus per-bit stability-counter
// debouncer for the raw NVBoard buttons and switches. Produces clean levels,
// one-cycle press/release pulses per button, and a pulse whenever the mux
// select field sw_db[5:4] changes.
module input_debounce #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] btn,
    input  logic [7:0] sw,
    output logic [4:0] btn_db,
    output logic [7:0] sw_db,
    output logic [4:0] btn_press,
    output logic [4:0] btn_release,
    output logic       sel_change
);

    // Bits 12:8 carry the buttons, bits 7:0 the switches.
    localparam int NB = 13;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [NB-1:0]    raw;
    logic [NB-1:0]    s1;
    logic [NB-1:0]    s2;
    logic [NB-1:0]    db;
    logic [NB-1:0]    db_next;
    logic [CNT_W-1:0] cnt      [NB];
    logic [CNT_W-1:0] cnt_next [NB];

    assign raw = {btn, sw};

    // Two-flop synchroniser; only s2 is consumed by the debouncer.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Per-bit stability counter: any agreement with db clears the count, a
    // full run of STABLE_CYCLES disagreeing samples flips db.
    always_comb begin
        db_next = db;
        for (int i = 0; i < NB; i++) begin
            cnt_next[i] = '0;
            if (s2[i] != db[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    db_next[i] = s2[i];
                end else begin
                    cnt_next[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Debounced state, counters and edge pulses; pulses are derived from the
    // db transition taken on this same edge so they align with the new level.
    always_ff @(posedge clk) begin
        if (rst) begin
            db          <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            sel_change  <= 1'b0;
            for (int i = 0; i < NB; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            db          <= db_next;
            btn_press   <= db_next[12:8] & ~db[12:8];
            btn_release <= ~db_next[12:8] & db[12:8];
            sel_change  <= (db_next[5:4] != db[5:4]);
            for (int i = 0; i < NB; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    assign btn_db = db[12:8];
    assign sw_db  = db[7:0];

endmodule

// File: tb/tb_input_debounce.sv
// tb_input_debounce: directed scenarios plus a randomized run, each output
// checked against a window-based behavioural model of the debouncer.
module tb_input_debounce;

    localparam int S = 4;
    localparam int HMAX = 4096;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] btn;
    logic [7:0] sw;
    logic [4:0] btn_db;
    logic [7:0] sw_db;
    logic [4:0] btn_press;
    logic [4:0] btn_release;
    logic       sel_change;

    input_debounce #(.STABLE_CYCLES(S), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .btn(btn), .sw(sw),
        .btn_db(btn_db), .sw_db(sw_db), .btn_press(btn_press),
        .btn_release(btn_release), .sel_change(sel_change)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model state: raw values seen at each edge (0 on reset edges).
    logic [12:0] raw_at [HMAX];
    int          k = 0;
    int          last_rst = 0;
    logic [12:0] m_db = '0;
    logic [4:0]  m_press = '0;
    logic [4:0]  m_rel = '0;
    logic        m_sel = 1'b0;

    logic [23:0] obs;
    assign obs = {btn_db, sw_db, btn_press, btn_release, sel_change};

    function automatic logic [23:0] exp_vec();
        return {m_db[12:8], m_db[7:0], m_press, m_rel, m_sel};
    endfunction

    // Apply one cycle of inputs, then advance the model. Debouncing at edge j
    // sees the raw value applied two edges earlier; a bit flips when the last
    // S post-reset edges all saw a value opposite to the current level.
    task automatic step(input logic r, input logic [4:0] b, input logic [7:0] s);
        logic [12:0] nd;
        logic [12:0] sv;
        bit          all_diff;
        rst = r; btn = b; sw = s;
        @(posedge clk); #1;
        k++;
        if (k >= HMAX) begin
            $display("FAIL history overflow: edge %0d, limit %0d", k, HMAX);
            $fatal(1);
        end
        if (r) begin
            raw_at[k] = '0; last_rst = k;
            m_db = '0; m_press = '0; m_rel = '0; m_sel = 1'b0;
        end else begin
            raw_at[k] = {b, s};
            nd = m_db;
            for (int i = 0; i < 13; i++) begin
                all_diff = (k - S + 1 > last_rst);
                for (int j = k - S + 1; j <= k; j++) begin
                    if (all_diff) begin
                        sv = (j - 2 < last_rst) ? 13'd0 : raw_at[j-2];
                        if (sv[i] == m_db[i]) all_diff = 1'b0;
                    end
                end
                if (all_diff) nd[i] = ~m_db[i];
            end
            m_press = nd[12:8] & ~m_db[12:8];
            m_rel   = ~nd[12:8] & m_db[12:8];
            m_sel   = (nd[5:4] != m_db[5:4]);
            m_db    = nd;
        end
    endtask

    task automatic test_reset();
        for (int n = 1; n <= 23; n++) begin
            step(n <= 3, 5'd0, 8'd0);
            n_vec++;
            if (obs !== 24'd0) begin
                n_err++;
                $display("FAIL reset_idle step %0d: got %h want 000000", n, obs);
            end
        end
    endtask

    task automatic test_clean_press();
        for (int n = 1; n <= 18; n++) begin
            step(1'b0, (n <= 10) ? 5'b00100 : 5'b00000, 8'd0);
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL clean_press model step %0d: got %h want %h", n, obs, exp_vec());
            end
            if (n == 5) begin
                n_vec++;
                if (btn_db !== 5'b00000) begin
                    n_err++;
                    $display("FAIL clean_press early: btn_db got %b want 00000", btn_db);
                end
            end
            if (n == 6) begin
                n_vec++;
                if ({btn_db, btn_press} !== {5'b00100, 5'b00100}) begin
                    n_err++;
                    $display("FAIL clean_press edge6: btn_db/press got %b/%b want 00100/00100", btn_db, btn_press);
                end
            end
            if (n == 7) begin
                n_vec++;
                if (btn_press !== 5'b00000) begin
                    n_err++;
                    $display("FAIL clean_press pulse_len: btn_press got %b want 00000", btn_press);
                end
            end
            if (n <= 10) begin
                n_vec++;
                if (btn_release !== 5'b00000) begin
                    n_err++;
                    $display("FAIL clean_press release: got %b want 00000", btn_release);
                end
            end
        end
    endtask

    task automatic test_bounce();
        for (int n = 1; n <= 30; n++) begin
            logic [7:0] s;
            if (n <= 8) s = (n % 2 == 1) ? 8'h01 : 8'h00;
            else if (n <= 14) s = 8'h00;
            else if (n <= 22) s = 8'h01;
            else s = 8'h00;
            step(1'b0, 5'd0, s);
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL bounce model step %0d: got %h want %h", n, obs, exp_vec());
            end
            if (n <= 14) begin
                n_vec++;
                if ({sw_db[0], sel_change} !== 2'b00) begin
                    n_err++;
                    $display("FAIL bounce reject step %0d: sw_db0/sel got %b%b want 00", n, sw_db[0], sel_change);
                end
            end
            if (n == 19 || n == 20) begin
                n_vec++;
                if (sw_db[0] !== (n == 20)) begin
                    n_err++;
                    $display("FAIL bounce hold step %0d: sw_db0 got %b want %b", n, sw_db[0], (n == 20));
                end
            end
        end
    endtask

    task automatic test_sel_change();
        for (int n = 1; n <= 26; n++) begin
            logic [7:0] s;
            s = (n <= 9) ? 8'h30 : (n <= 18) ? 8'h10 : 8'h00;
            step(1'b0, 5'd0, s);
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL sel_change model step %0d: got %h want %h", n, obs, exp_vec());
            end
            if (n == 6 || n == 15) begin
                n_vec++;
                if ({sw_db, sel_change} !== {((n == 6) ? 8'h30 : 8'h10), 1'b1}) begin
                    n_err++;
                    $display("FAIL sel_change step %0d: sw_db/sel got %h/%b want %h/1", n, sw_db, sel_change, (n == 6) ? 8'h30 : 8'h10);
                end
            end
            if (n == 7 || n == 16) begin
                n_vec++;
                if (sel_change !== 1'b0) begin
                    n_err++;
                    $display("FAIL sel_change pulse_len step %0d: got %b want 0", n, sel_change);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 1; n <= 20; n++) begin
            step(1'b0, (n <= 10) ? 5'b10001 : 5'b00000, 8'd0);
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL simultaneous model step %0d: got %h want %h", n, obs, exp_vec());
            end
            if (n == 6) begin
                n_vec++;
                if (btn_press !== 5'b10001) begin
                    n_err++;
                    $display("FAIL simultaneous press: got %b want 10001", btn_press);
                end
            end
            if (n == 16) begin
                n_vec++;
                if (btn_release !== 5'b10001) begin
                    n_err++;
                    $display("FAIL simultaneous release: got %b want 10001", btn_release);
                end
            end
        end
    endtask

    task automatic test_reset_mid_count();
        for (int n = 1; n <= 22; n++) begin
            step(n == 4, (n <= 14) ? 5'b00010 : 5'b00000, 8'd0);
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL reset_mid model step %0d: got %h want %h", n, obs, exp_vec());
            end
            if (n <= 9) begin
                n_vec++;
                if ({btn_db, btn_press, btn_release} !== 15'd0) begin
                    n_err++;
                    $display("FAIL reset_mid early step %0d: db/press/rel got %b/%b/%b want 0", n, btn_db, btn_press, btn_release);
                end
            end
            if (n == 10) begin
                n_vec++;
                if ({btn_db, btn_press} !== {5'b00010, 5'b00010}) begin
                    n_err++;
                    $display("FAIL reset_mid rise: db/press got %b/%b want 00010/00010", btn_db, btn_press);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [12:0] cur;
        cur = '0;
        for (int n = 1; n <= 500; n++) begin
            int c;
            c = $urandom_range(0, 9);
            if (c <= 1) cur[$urandom_range(0, 12)] ^= 1'b1;
            else if (c == 2) cur[4] ^= 1'b1;
            else if (c == 3 && n % 50 < 10) cur[12:8] ^= 5'($urandom_range(0, 31));
            step($urandom_range(0, 99) == 0, cur[12:8], cur[7:0]);
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL random step %0d: got %h want %h", n, obs, exp_vec());
            end
        end
    endtask

    initial begin
        rst = 1'b1; btn = '0; sw = '0;
        for (int i = 0; i < HMAX; i++) raw_at[i] = '0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_sel_change();
        test_back_to_back();
        test_reset_mid_count();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
